// File: rtl/freq_meas_pkg.sv
// Shared types for the frequency measurement sequencer: FSM states and the
// result status codes returned with each measurement.
package freq_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET_DET,
    WAIT_GAIN,
    WAIT_STABLE,
    ACCUM,
    REPORT
  } state_t;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_TIMEOUT   = 2'b01;
  localparam logic [1:0] ST_LOST_LOCK = 2'b10;

endpackage

// File: rtl/freq_measure_period_averager.sv
// Sums 2^AVG_LOG2 detector periods taken every SAMPLE_INTERVAL cycles and
// presents the truncated mean on the cycle the last sample lands.
module period_averager #(
  parameter int PERIOD_WIDTH    = 16,
  parameter int AVG_LOG2        = 2,
  parameter int SAMPLE_INTERVAL = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [PERIOD_WIDTH-1:0] det_period,
  output logic                    done,
  output logic [PERIOD_WIDTH-1:0] avg
);

  localparam int IW = $clog2(SAMPLE_INTERVAL + 1);
  localparam int AW = PERIOD_WIDTH + AVG_LOG2;

  logic [IW-1:0]       interval_cnt;
  logic [AVG_LOG2-1:0] sample_cnt;
  logic [AW-1:0]       acc;
  logic [AW-1:0]       acc_sum;
  logic                sample;

  assign sample  = enable && (interval_cnt == IW'(SAMPLE_INTERVAL - 1));
  assign acc_sum = acc + AW'(det_period);
  assign done    = sample && (sample_cnt == '1);
  assign avg     = PERIOD_WIDTH'(acc_sum >> AVG_LOG2);

  // The block returns to its cleared state on its own after the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_cnt <= '0;
      sample_cnt   <= '0;
      acc          <= '0;
    end else if (clear) begin
      interval_cnt <= '0;
      sample_cnt   <= '0;
      acc          <= '0;
    end else if (enable) begin
      if (sample) begin
        interval_cnt <= '0;
        sample_cnt   <= sample_cnt + AVG_LOG2'(1);
        acc          <= done ? '0 : acc_sum;
      end else begin
        interval_cnt <= interval_cnt + IW'(1);
      end
    end
  end

endmodule

// File: rtl/freq_measure_ctrl.sv
// Measurement sequencer for the zero-crossing frequency detector (adc_clk domain).
// Define FREQ_MEAS_CONTINUOUS_EN to keep measuring after each successful report.
module freq_measure_ctrl
  import freq_meas_pkg::*;
#(
  parameter int PERIOD_WIDTH    = 16,
  parameter int AVG_LOG2        = 2,
  parameter int SAMPLE_INTERVAL = 64,
  parameter int SETTLE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int MAX_RETRY       = 3
) (
  input  logic                    adc_clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    gain_stable,
  input  logic [PERIOD_WIDTH-1:0] det_period,
  input  logic                    det_stable,
  output logic                    det_rst_n,
  output logic                    busy,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [PERIOD_WIDTH-1:0] res_period,
  output logic [1:0]              res_status
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  state_t                  state, next_state;
  logic [SW-1:0]           settle_cnt;
  logic [TW-1:0]           tmo_cnt;
  logic [RW-1:0]           retry_cnt, retry_nxt;
  logic                    tmo_hit, fail, load_res;
  logic [1:0]              fail_code, status_nxt;
  logic [PERIOD_WIDTH-1:0] period_nxt, avg;
  logic                    avg_clear, avg_en, avg_done;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  period_averager #(
    .PERIOD_WIDTH   (PERIOD_WIDTH),
    .AVG_LOG2       (AVG_LOG2),
    .SAMPLE_INTERVAL(SAMPLE_INTERVAL)
  ) u_avg (
    .clk       (adc_clk),
    .rst_n     (rst_n),
    .clear     (avg_clear),
    .enable    (avg_en),
    .det_period(det_period),
    .done      (avg_done),
    .avg       (avg)
  );

  always_comb begin
    next_state = state;
    retry_nxt  = retry_cnt;
    load_res   = 1'b0;
    period_nxt = '0;
    status_nxt = ST_OK;
    avg_clear  = 1'b1;
    avg_en     = 1'b0;
    fail       = 1'b0;
    fail_code  = ST_OK;
    case (state)
      IDLE: begin
        if (!stop && start) begin
          next_state = RESET_DET;
          retry_nxt  = '0;
        end
      end
      RESET_DET: begin
        if (stop) next_state = IDLE;
        else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) next_state = WAIT_GAIN;
      end
      WAIT_GAIN: begin
        if (stop) next_state = IDLE;
        else if (gain_stable) next_state = WAIT_STABLE;
        else if (tmo_hit) begin
          fail      = 1'b1;
          fail_code = ST_TIMEOUT;
        end
      end
      WAIT_STABLE: begin
        if (stop) next_state = IDLE;
        else if (det_stable) next_state = ACCUM;
        else if (tmo_hit) begin
          fail      = 1'b1;
          fail_code = ST_TIMEOUT;
        end
      end
      ACCUM: begin
        avg_clear = 1'b0;
        if (stop) next_state = IDLE;
        else if (!det_stable || !gain_stable) begin
          // Losing lock discards any sample that would have landed this cycle.
          fail      = 1'b1;
          fail_code = ST_LOST_LOCK;
        end else begin
          avg_en = 1'b1;
          if (avg_done) begin
            next_state = REPORT;
            load_res   = 1'b1;
            period_nxt = avg;
          end
        end
      end
      REPORT: begin
        if (res_valid && res_ready) begin
          next_state = IDLE;
`ifdef FREQ_MEAS_CONTINUOUS_EN
          if (res_status == ST_OK) begin
            retry_nxt = '0;
            if (det_stable && gain_stable) begin
              // The handshake cycle counts as the first interval cycle, so
              // back-to-back results keep a fixed cadence.
              next_state = ACCUM;
              avg_clear  = 1'b0;
              avg_en     = 1'b1;
            end else begin
              next_state = WAIT_GAIN;
            end
          end
`endif
        end
      end
      default: next_state = IDLE;
    endcase

    if (fail) begin
      if (retry_cnt < RW'(MAX_RETRY)) begin
        retry_nxt  = retry_cnt + RW'(1);
        next_state = RESET_DET;
      end else begin
        next_state = REPORT;
        load_res   = 1'b1;
        period_nxt = '0;
        status_nxt = fail_code;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      tmo_cnt    <= '0;
      retry_cnt  <= '0;
      det_rst_n  <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_period <= '0;
      res_status <= ST_OK;
    end else begin
      state      <= next_state;
      retry_cnt  <= retry_nxt;
      settle_cnt <= (state == RESET_DET) ? settle_cnt + SW'(1) : '0;
      tmo_cnt    <= (state == WAIT_GAIN || state == WAIT_STABLE) ? tmo_cnt + TW'(1) : '0;
      busy       <= (state != IDLE);
      det_rst_n  <= !(state == IDLE || state == RESET_DET);
      if (load_res) begin
        res_valid  <= 1'b1;
        res_period <= period_nxt;
        res_status <= status_nxt;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Directed bench for freq_measure_ctrl with small timing parameters.
module tb_freq_measure_ctrl;

  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          gain_stable = 1'b0;
  logic          det_stable = 1'b0;
  logic          res_ready = 1'b0;
  logic [PW-1:0] det_period = '0;
  logic          det_rst_n, busy, res_valid;
  logic [PW-1:0] res_period;
  logic [1:0]    res_status;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  freq_measure_ctrl #(
    .PERIOD_WIDTH   (PW),
    .AVG_LOG2       (2),
    .SAMPLE_INTERVAL(8),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100),
    .MAX_RETRY      (1)
  ) dut (
    .adc_clk    (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .gain_stable(gain_stable),
    .det_period (det_period),
    .det_stable (det_stable),
    .det_rst_n  (det_rst_n),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_period (res_period),
    .res_status (res_status)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_release(input string tag);
    int n;
    n = 0;
    while (det_rst_n !== 1'b0 && n < 300) begin step(1); n++; end
    while (det_rst_n !== 1'b1 && n < 300) begin step(1); n++; end
    check_eq(tag, n < 300, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (res_valid !== 1'b1 && n < budget) begin step(1); n++; end
    check_eq(tag, res_valid, 1);
  endtask

  // Call right after raising det_stable; ACCUM starts on the next edge and
  // each value is centred on its sampling edge.
  task automatic feed4(input logic [PW-1:0] a, b, c, d);
    step(5); det_period = a;
    step(8); det_period = b;
    step(8); det_period = c;
    step(8); det_period = d;
    step(4);
  endtask

  task automatic lose_after_two(input string tag);
    wait_release(tag);
    step(2);
    det_stable = 1'b1;
    step(20);
    det_stable = 1'b0;
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    check_eq(tag, res_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, pulses, changes, vcount, n, t1, t2, t3;
    logic prev, flag;
    logic [PW-1:0] snap_p;
    logic [1:0] snap_s;

    step(2);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_det_rst_n", det_rst_n, 0);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_period", res_period, 0);
    check_eq("rst_status", res_status, 0);
    rst_n = 1'b1;
    gain_stable = 1'b1;
    step(2);

`ifndef FREQ_MEAS_CONTINUOUS_EN
    // Happy path
    pulse_start();
    low = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (busy && !det_rst_n) low++;
    end
    check_eq("t1_settle_len", low, 4);
    step(9);
    det_stable = 1'b1;
    feed4(16'd1000, 16'd1002, 16'd1001, 16'd1003);
    check_eq("t1_valid", res_valid, 1);
    check_eq("t1_period", res_period, 1001);
    check_eq("t1_status", res_status, 0);
    handshake("t1_valid_drop");
    step(1);
    check_eq("t1_idle", busy, 0);
    det_stable = 1'b0;
`endif

    // Timeout on both attempts
    pulse_start();
    pulses = 0; prev = 1'b0; n = 0;
    while (res_valid !== 1'b1 && n < 500) begin
      flag = busy && !det_rst_n;
      if (flag && !prev) pulses++;
      prev = flag;
      step(1);
      n++;
    end
    check_eq("t2_valid", res_valid, 1);
    check_eq("t2_reset_pulses", pulses, 2);
    check_eq("t2_status", res_status, 1);
    check_eq("t2_period", res_period, 0);
    handshake("t2_valid_drop");
    step(1);
    check_eq("t2_idle", busy, 0);

`ifndef FREQ_MEAS_CONTINUOUS_EN
    // One lock loss, relock on retry
    pulse_start();
    lose_after_two("t3b_first");
    wait_release("t3b_retry");
    step(2);
    det_stable = 1'b1;
    feed4(16'd2001, 16'd2002, 16'd2002, 16'd2002);
    check_eq("t3b_valid", res_valid, 1);
    check_eq("t3b_status", res_status, 0);
    check_eq("t3b_period", res_period, 2001);
    handshake("t3b_valid_drop");
    det_stable = 1'b0;
    step(2);

    // Lock lost on both attempts
    pulse_start();
    lose_after_two("t3a_first");
    lose_after_two("t3a_second");
    wait_valid("t3a_valid", 100);
    check_eq("t3a_status", res_status, 2);
    check_eq("t3a_period", res_period, 0);
    handshake("t3a_valid_drop");
    step(2);

    // Backpressure
    pulse_start();
    wait_release("t4_release");
    step(2);
    det_stable = 1'b1;
    feed4(16'd500, 16'd501, 16'd502, 16'd503);
    check_eq("t4_valid", res_valid, 1);
    snap_p = res_period;
    snap_s = res_status;
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      start = i[0];
      stop  = (i == 10);
      step(1);
      if (res_valid !== 1'b1 || res_period !== snap_p || res_status !== snap_s) changes++;
    end
    start = 1'b0;
    stop  = 1'b0;
    check_eq("t4_hold_changes", changes, 0);
    check_eq("t4_period", res_period, 501);
    handshake("t4_valid_drop");
    step(1);
    check_eq("t4_idle", busy, 0);
    det_stable = 1'b0;

    // Abort from WAIT_STABLE
    pulse_start();
    wait_release("t5_release");
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
    check_eq("t5_stop_busy", busy, 0);
    check_eq("t5_stop_det_rst_n", det_rst_n, 0);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (res_valid) vcount++;
    end
    check_eq("t5_no_result", vcount, 0);

    // Reset during ACCUM
    pulse_start();
    wait_release("t5r_release");
    step(2);
    det_stable = 1'b1;
    step(10);
    check_eq("t5r_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5r_busy", busy, 0);
    check_eq("t5r_det_rst_n", det_rst_n, 0);
    check_eq("t5r_valid", res_valid, 0);
    check_eq("t5r_period", res_period, 0);
    check_eq("t5r_status", res_status, 0);
    step(2);
    rst_n = 1'b1;
    det_stable = 1'b0;
    step(2);
    check_eq("t5r_idle", busy, 0);
`else
    // Continuous run on a locked input
    det_period = 16'd700;
    det_stable = 1'b1;
    res_ready  = 1'b1;
    pulse_start();
    wait_valid("t6_first", 100);
    t1 = cyc;
    check_eq("t6_period", res_period, 700);
    check_eq("t6_status", res_status, 0);
    low = 0;
    step(1);
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      if (!det_rst_n) low++;
      step(1);
      n++;
    end
    check_eq("t6_second", res_valid, 1);
    t2 = cyc;
    check_eq("t6_spacing1", t2 - t1, 32);
    step(1);
    n = 0;
    while (res_valid !== 1'b1 && n < 100) begin
      if (!det_rst_n) low++;
      step(1);
      n++;
    end
    check_eq("t6_third", res_valid, 1);
    t3 = cyc;
    check_eq("t6_spacing2", t3 - t2, 32);
    check_eq("t6_no_det_reset", low, 0);
    step(5);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
    check_eq("t6_stop_busy", busy, 0);
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (res_valid) vcount++;
    end
    check_eq("t6_stopped", vcount, 0);
    res_ready = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_measure_ctrl.md
Name: freq_measure_ctrl

Overview:
- Measurement sequencer for the zero-crossing frequency detector, in the ADC clock domain.
- On a start request it resets the detector, waits for gain-control stability, then waits for detector frequency lock with a timeout.
- Once locked it averages 2^AVG_LOG2 period samples and returns the result with a status code over a valid/ready handshake.
- Retries automatically on timeout or loss of lock.

Parameters:
- PERIOD_WIDTH, 16, width of the detector period and result period.
- AVG_LOG2, 2, log2 of the number of averaged samples (1..4).
- SAMPLE_INTERVAL, 64, adc_clk cycles between period samples in ACCUM.
- SETTLE_CYCLES, 16, cycles det_rst_n is held low per attempt (≥1).
- TIMEOUT_CYCLES, 1000000, maximum cycles from the end of RESET_DET to lock.
- MAX_RETRY, 3, number of extra attempts after the first failure.

Ports:
- adc_clk  in  1  ADC domain clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle measurement request; honoured only in IDLE.
- stop  in  1  abort; returns to IDLE from any state except REPORT.
- gain_stable  in  1  gain-control loop settled.
- det_period  in  PERIOD_WIDTH  detector period output.
- det_stable  in  1  detector stable flag.
- det_rst_n  out  1  active-low reset to the detector.
- busy  out  1  high whenever state != IDLE.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_period  out  PERIOD_WIDTH  averaged period in adc_clk cycles; 0 on failure.
- res_status  out  2  00 OK, 01 TIMEOUT, 10 LOST_LOCK, 11 reserved.

Behaviour:
- Clocking and reset: single clock adc_clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, det_rst_n 0, busy 0, res_valid 0, res_period 0, res_status 00, all counters 0.
- Registered outputs: all outputs are registered; busy and det_rst_n follow state with 1 cycle of latency.
- IDLE:
  - det_rst_n=0.
  - start=1 → RESET_DET and retry_cnt=0.
  - stop has priority over start in the same cycle.
- RESET_DET:
  - det_rst_n=0 for exactly SETTLE_CYCLES cycles, then → WAIT_GAIN.
  - Timeout counter cleared on exit.
- WAIT_GAIN:
  - det_rst_n=1, timeout counter increments.
  - gain_stable=1 → WAIT_STABLE.
- WAIT_STABLE:
  - Timeout counter continues.
  - det_stable=1 → ACCUM, with sample counter and accumulator cleared and interval counter = 0.
- ACCUM:
  - Interval counter counts 0..SAMPLE_INTERVAL-1; on reaching SAMPLE_INTERVAL-1, det_period is added to the accumulator.
  - After 2^AVG_LOG2 samples: res_period = acc >> AVG_LOG2 (truncating), res_status=00 → REPORT.
- Accumulator width: PERIOD_WIDTH+AVG_LOG2 bits; overflow is impossible.
- Timeout: counter reaching TIMEOUT_CYCLES-1 in WAIT_GAIN/WAIT_STABLE is a failure with code TIMEOUT.
- Loss of lock: det_stable=0 or gain_stable=0 during ACCUM is a failure with code LOST_LOCK.
  - This takes priority over a sample landing in the same cycle; the sample is discarded.
- Failure handling:
  - retry_cnt < MAX_RETRY → retry_cnt+1 → RESET_DET.
  - Otherwise res_period=0, res_status=code → REPORT.
- REPORT:
  - res_valid=1; res_period and res_status held constant while valid.
  - The transfer completes on res_valid && res_ready; the next cycle has res_valid=0 and state IDLE.
  - stop and start are ignored in REPORT.
- stop: in RESET_DET/WAIT_*/ACCUM, stop → IDLE next cycle, no result produced, det_rst_n=0.
- Reset mid-operation: immediate return to reset values; any pending result is lost.

Optional Feature:
- Macro: FREQ_MEAS_CONTINUOUS_EN.
- Defined:
  - After a successful REPORT handshake (status 00), go directly to ACCUM if det_stable && gain_stable, else to WAIT_GAIN with the timeout counter cleared. The detector is not reset and retry_cnt is cleared.
  - Failed reports still return to IDLE.
  - stop is the only way to end a continuous run.
- Undefined: every handshake returns to IDLE; one measurement per start.

Decomposition:
- Shared package freq_meas_pkg:
  - state enum (IDLE, RESET_DET, WAIT_GAIN, WAIT_STABLE, ACCUM, REPORT);
  - status code constants (ST_OK, ST_TIMEOUT, ST_LOST_LOCK).
- Sub-module period_averager:
  - contains the interval counter, sample counter, accumulator and shift;
  - inputs clear/enable/det_period; outputs done/avg.
- The FSM, timeout and retry logic stay in freq_measure_ctrl.

Test Plan:
Bench parameters: SETTLE_CYCLES=4, TIMEOUT_CYCLES=100, SAMPLE_INTERVAL=8, AVG_LOG2=2, MAX_RETRY=1.
1. Happy path: start; gain_stable=1; det_stable=1 at cycle 20; det_period 1000,1002,1001,1003 → res_valid, res_period=1001, status 00. det_rst_n is low for exactly 4 cycles.
2. Timeout: gain_stable=1, det_stable never asserted → two RESET_DET pulses, then res_status=01, res_period=0.
3. Lost lock: drop det_stable after 2 samples on both attempts → status 10. A single drop followed by relock on the retry → status 00.
4. Backpressure: hold res_ready=0 for 50 cycles → res_valid and outputs stay constant; start pulses are ignored. res_ready=1 → IDLE next cycle.
5. Abort and reset: stop in WAIT_STABLE → IDLE next cycle, no res_valid. rst_n low during ACCUM → all outputs at reset values immediately.
6. With FREQ_MEAS_CONTINUOUS_EN: locked input, res_ready=1 → consecutive results every 32 cycles with no det_rst_n pulse; stop ends the run.
